// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer_filler / buffer_drainer byte-link pair.
package buffer_pkg;

  // Default word and byte widths used by both ends of the byte link
  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned DEF_BYTE_W = 8;

  // Drainer control state: waiting for a word, or streaming its bytes
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

endpackage : buffer_pkg

// File: rtl/buffer_drainer_if.sv
// Word-in / byte-out handshake bundle for the buffer drainer.
interface buffer_drainer_if #(
  parameter int unsigned WORD_W = buffer_pkg::DEF_WORD_W,
  parameter int unsigned BYTE_W = buffer_pkg::DEF_BYTE_W
);

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              busy;
  logic              word_done;

  // Upstream word source and downstream byte sink, seen from outside the drainer
  modport master (
    output word_in, word_valid, byte_ready,
    input  word_ready, byte_out, byte_valid, busy, word_done
  );

  // The drainer itself
  modport slave (
    input  word_in, word_valid, byte_ready,
    output word_ready, byte_out, byte_valid, busy, word_done
  );

endinterface : buffer_drainer_if

// File: rtl/buffer_drainer.sv
// Word-to-byte serializer: takes one word over valid/ready and emits its bytes
// (MSB first unless LSB_FIRST) over a second valid/ready handshake, with
// zero-bubble streaming of back-to-back words.
module buffer_drainer
  import buffer_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned BYTE_W    = DEF_BYTE_W,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  buffer_drainer_if.slave bus
);

  localparam int unsigned NUM_BYTES = WORD_W / BYTE_W;
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  drain_state_t      state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shreg_q;
  logic [BYTE_W-1:0] byte_q;
  logic              byte_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [IDX_W-1:0]  idx_d;
  logic [BYTE_W-1:0] byte_d;
  logic [BYTE_W-1:0] first_byte_d;
  logic              last_c;
  logic              word_ready_c;
  logic              accept_c;
  logic              xfer_c;

  // Byte k of a word in transmit order; byte 0 is the first one sent
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  k);
    int unsigned base;
    if (LSB_FIRST) begin
      base = 32'(k) * BYTE_W;
    end else begin
      base = (NUM_BYTES - 1 - 32'(k)) * BYTE_W;
    end
    return BYTE_W'(w >> base);
  endfunction

  // Handshake decode; word_ready is the only path from byte_ready to an output
  always_comb begin
    last_c       = (idx_q == LAST_IDX);
    word_ready_c = (state_q == IDLE) ||
                   ((state_q == SEND) && last_c && bus.byte_ready);
    accept_c     = bus.word_valid && word_ready_c;
    xfer_c       = byte_valid_q && bus.byte_ready;
  end

  // Next byte of the current word and first byte of an incoming word
  always_comb begin
    idx_d        = idx_q + IDX_W'(1);
    byte_d       = pick_byte(shreg_q, idx_d);
    first_byte_d = pick_byte(bus.word_in, '0);
  end

  // Control FSM with registered byte, valid, busy and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shreg_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q      <= SEND;
            shreg_q      <= bus.word_in;
            idx_q        <= '0;
            byte_q       <= first_byte_d;
            byte_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        SEND: begin
          if (xfer_c) begin
            if (last_c) begin
              done_q <= 1'b1;
              if (accept_c) begin
                // Reload in the same cycle so the next word follows with no bubble
                shreg_q <= bus.word_in;
                idx_q   <= '0;
                byte_q  <= first_byte_d;
              end else begin
                // byte_out keeps the last byte sent
                state_q      <= IDLE;
                byte_valid_q <= 1'b0;
                busy_q       <= 1'b0;
              end
            end else begin
              idx_q  <= idx_d;
              byte_q <= byte_d;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          byte_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Drive the interface from registered state
  assign bus.word_ready = word_ready_c;
  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.busy       = busy_q;
  assign bus.word_done  = done_q;

endmodule : buffer_drainer

// File: tb/tb_buffer_drainer.sv
// Bench for buffer_drainer: MSB-first and LSB-first instances driven in
// lockstep and compared against a byte-count reference model.
module tb_buffer_drainer;

  logic clk;
  logic rst;

  int unsigned n_vec;
  int unsigned n_miss;

  buffer_drainer_if #(.WORD_W(32), .BYTE_W(8)) bus_m ();
  buffer_drainer_if #(.WORD_W(32), .BYTE_W(8)) bus_l ();

  buffer_drainer #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  buffer_drainer #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 0 = MSB-first instance, 1 = LSB-first instance:
  // the word being sent, how many of its bytes are still owed, the last byte
  // handed over, and whether the final byte went out on the previous edge.
  logic [31:0] m_word [2];
  int          m_left [2];
  logic [7:0]  m_last [2];
  logic        m_done [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] nth_byte(input logic [31:0] w, input int k, input bit lsb);
    int sh;
    sh = lsb ? 8 * k : 8 * (3 - k);
    return 8'(w >> sh);
  endfunction

  function automatic logic [7:0] m_front(input int d);
    if (m_left[d] == 0) return m_last[d];
    return nth_byte(m_word[d], 4 - m_left[d], d == 1);
  endfunction

  function automatic logic m_ready(input int d, input logic br);
    return (m_left[d] == 0) || ((m_left[d] == 1) && br);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_word[d] = '0;
      m_left[d] = 0;
      m_last[d] = '0;
      m_done[d] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge with the given inputs
  task automatic model_step(input logic wv, input logic [31:0] w, input logic br);
    logic acc;
    for (int d = 0; d < 2; d++) begin
      acc       = wv && m_ready(d, br);
      m_done[d] = 1'b0;
      if ((m_left[d] > 0) && br) begin
        if (m_left[d] == 1) begin
          m_last[d] = m_front(d);
          m_done[d] = 1'b1;
        end
        m_left[d]--;
      end
      if (acc) begin
        m_word[d] = w;
        m_left[d] = 4;
      end
    end
  endtask

  task automatic check_side(input string side, input int d, input logic br,
                            input logic wr, input logic [7:0] bo, input logic bv,
                            input logic bs, input logic wd);
    check_eq({side, ".word_ready"}, 32'(wr), 32'(m_ready(d, br)));
    check_eq({side, ".byte_valid"}, 32'(bv), 32'(m_left[d] > 0));
    check_eq({side, ".byte_out"},   32'(bo), 32'(m_front(d)));
    check_eq({side, ".busy"},       32'(bs), 32'(m_left[d] > 0));
    check_eq({side, ".word_done"},  32'(wd), 32'(m_done[d]));
  endtask

  task automatic check_all(input logic br);
    check_side("msb", 0, br, bus_m.word_ready, bus_m.byte_out, bus_m.byte_valid,
               bus_m.busy, bus_m.word_done);
    check_side("lsb", 1, br, bus_l.word_ready, bus_l.byte_out, bus_l.byte_valid,
               bus_l.busy, bus_l.word_done);
  endtask

  task automatic drive(input logic wv, input logic [31:0] w, input logic br);
    bus_m.word_valid = wv;
    bus_m.word_in    = w;
    bus_m.byte_ready = br;
    bus_l.word_valid = wv;
    bus_l.word_in    = w;
    bus_l.byte_ready = br;
  endtask

  // One clock: drive on the falling edge, check, then predict the rising edge
  task automatic cycle(input logic wv, input logic [31:0] w, input logic br);
    @(negedge clk);
    drive(wv, w, br);
    #1;
    check_all(br);
    model_step(wv, w, br);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic reset_pulse();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(1'b0);
    @(negedge clk);
    #1;
    check_all(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] stall_pat [7];
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    model_reset();

    // Single word, sink always ready
    reset_pulse();
    cycle(1'b1, 32'h12345678, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Same word through a stall pattern
    stall_pat = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1};
    cycle(1'b1, 32'h12345678, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, stall_pat[i][0]);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

    // Two words back to back; the second is offered until taken on the last byte
    cycle(1'b1, 32'hABCDEF01, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h11223344, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Word offered mid-word under backpressure is refused until the last byte
    cycle(1'b1, 32'hA5A55A5A, 1'b0);
    cycle(1'b1, 32'h0F1E2D3C, 1'b1);
    cycle(1'b1, 32'h0F1E2D3C, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0F1E2D3C, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Reset after two bytes, then a clean word
    cycle(1'b1, 32'hDEADBEEF, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    reset_pulse();
    cycle(1'b1, 32'hCAFEF00D, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end else begin
        cycle(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 3) != 0));
      end
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_buffer_drainer
